trng_vector_source: RTL and testbench

- Entropy front end for the TRNG tile.
- A gated free-running ring oscillator is sampled through a 2-flop synchronizer into the clk domain.
- The sampled bits are optionally whitened by a von Neumann corrector, then packed into an 8-bit vector.
- Each vector is handed out with a valid/request handshake and drives the tile's byte output.
- A test mode replaces the oscillator with a deterministic input so the datapath can be simulated.

---
 rtl/trng_vector_source.sv | 141 ++++++++++++++
 tb/tb_trng_vector_source.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/trng_vector_source.sv
// Entropy front end: gated ring oscillator, 2-flop synchronizer, optional von Neumann
// corrector and an 8-bit packer with a valid/request handshake.
module trng_vector_source #(
   parameter int unsigned RING_STAGES = 32'd7,
   parameter bit          DEBIAS      = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       req,
   input  logic       test_mode,
   input  logic       test_bit,
   output logic       bit_valid,
   output logic [7:0] vector,
   output logic       vector_valid
);

   (* keep = "true" *) logic [RING_STAGES-1:0] ring_s;
   logic       ring_en_s;
   logic       source_s;
   logic       collect_s;
   logic       consume_s;
   logic       cand_valid_s;
   logic       cand_bit_s;
   logic       sync1_r;
   logic       sync2_r;
   logic [1:0] fill_r;
   logic       bit_valid_r;
   logic       phase_r;
   logic       first_r;
   logic [3:0] count_r;
   logic [7:0] vector_r;
   logic       vector_valid_r;

   // The ring is parked in test mode so the datapath simulates deterministically.
   assign ring_en_s = en & ~test_mode;
   assign ring_s[0] = ~(ring_en_s & ring_s[RING_STAGES-1]);

   for (genvar g = 1; g < RING_STAGES; g++) begin : g_inv
      assign ring_s[g] = ~ring_s[g-1];
   end

   // Entropy source selection.
   always_comb begin
      source_s = 1'b0;
      if (test_mode) begin
         source_s = test_bit;
      end else begin
         source_s = ring_s[RING_STAGES-1];
      end
   end

   assign collect_s = bit_valid_r & en;
   assign consume_s = req & vector_valid_r;

   // Candidate bit: straight through, or von Neumann on the second bit of each pair.
   always_comb begin
      cand_valid_s = 1'b0;
      cand_bit_s   = sync2_r;
      if (collect_s) begin
         if (DEBIAS) begin
            if (phase_r) begin
               cand_valid_s = (first_r != sync2_r);
               cand_bit_s   = first_r;
            end else begin
               cand_valid_s = 1'b0;
            end
         end else begin
            cand_valid_s = 1'b1;
         end
      end else begin
         cand_valid_s = 1'b0;
      end
   end

   // Synchronizer and fill tracking; bit_valid mirrors fill == 2.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_r     <= 1'b0;
         sync2_r     <= 1'b0;
         fill_r      <= 2'd0;
         bit_valid_r <= 1'b0;
      end else begin
         sync1_r <= source_s;
         sync2_r <= sync1_r;
         if (!en) begin
            fill_r      <= 2'd0;
            bit_valid_r <= 1'b0;
         end else if (fill_r == 2'd2) begin
            fill_r      <= fill_r;
            bit_valid_r <= 1'b1;
         end else begin
            fill_r      <= fill_r + 2'd1;
            bit_valid_r <= (fill_r == 2'd1);
         end
      end
   end

   // Pair phase for the corrector.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_r <= 1'b0;
         first_r <= 1'b0;
      end else if (!en || consume_s) begin
         phase_r <= 1'b0;
      end else if (collect_s) begin
         if (!phase_r) begin
            first_r <= sync2_r;
         end else begin
            first_r <= first_r;
         end
         phase_r <= ~phase_r;
      end else begin
         phase_r <= phase_r;
      end
   end

   // Packer and handshake; a full vector freezes until consumed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r        <= 4'd0;
         vector_r       <= 8'h00;
         vector_valid_r <= 1'b0;
      end else if (consume_s) begin
         count_r        <= 4'd0;
         vector_valid_r <= 1'b0;
      end else if (cand_valid_s && !vector_valid_r) begin
         vector_r       <= {vector_r[6:0], cand_bit_s};
         count_r        <= count_r + 4'd1;
         vector_valid_r <= (count_r == 4'd7);
      end else begin
         count_r        <= count_r;
         vector_valid_r <= vector_valid_r;
      end
   end

   assign bit_valid    = bit_valid_r;
   assign vector       = vector_r;
   assign vector_valid = vector_valid_r;

endmodule

// File: tb/tb_trng_vector_source.sv
// Directed bench for trng_vector_source: one instance without and one with the corrector.
module tb_trng_vector_source;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic       req;
   logic       test_mode;
   logic       test_bit;
   logic       bv0, vv0, bv1, vv1;
   logic [7:0] vec0, vec1;
   int         n_cmp;
   int         n_fail;

   trng_vector_source #(.RING_STAGES(32'd7), .DEBIAS(1'b0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .en(en), .req(req), .test_mode(test_mode),
      .test_bit(test_bit), .bit_valid(bv0), .vector(vec0), .vector_valid(vv0));

   trng_vector_source #(.RING_STAGES(32'd7), .DEBIAS(1'b1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .en(en), .req(req), .test_mode(test_mode),
      .test_bit(test_bit), .bit_valid(bv1), .vector(vec1), .vector_valid(vv1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic edge_();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      #2;
      n_cmp++; if (vec0 !== 8'h00) begin n_fail++; $display("FAIL reset_vec0: got %h want 00", vec0); end
      n_cmp++; if (vv0 !== 1'b0 || bv0 !== 1'b0) begin n_fail++; $display("FAIL reset_flags0: got vv=%b bv=%b want 0 0", vv0, bv0); end
      n_cmp++; if (vec1 !== 8'h00 || vv1 !== 1'b0 || bv1 !== 1'b0) begin n_fail++; $display("FAIL reset_dut1: got %h %b %b want 00 0 0", vec1, vv1, bv1); end
      edge_();
      rst_n = 1'b1;
   endtask

   task automatic test_straight();
      logic [7:0] pat;
      pat = 8'b1011_0010;
      reset_dut();
      en = 1'b1; test_mode = 1'b1; req = 1'b0;
      for (int i = 0; i < 8; i++) begin
         test_bit = pat[7-i];
         edge_();
         if (i == 0) begin
            n_cmp++; if (bv0 !== 1'b0) begin n_fail++; $display("FAIL bv_edge1: got %b want 0", bv0); end
         end
         if (i == 1) begin
            n_cmp++; if (bv0 !== 1'b1) begin n_fail++; $display("FAIL bv_edge2: got %b want 1", bv0); end
         end
      end
      test_bit = 1'b1;
      edge_();
      n_cmp++; if (vv0 !== 1'b0) begin n_fail++; $display("FAIL vv_edge9: got %b want 0", vv0); end
      test_bit = 1'b0;
      edge_();
      n_cmp++; if (vv0 !== 1'b1) begin n_fail++; $display("FAIL vv_edge10: got %b want 1", vv0); end
      n_cmp++; if (vec0 !== 8'hB2) begin n_fail++; $display("FAIL vec_b2: got %h want b2", vec0); end
   endtask

   task automatic test_hold_consume();
      for (int i = 0; i < 2; i++) begin
         test_bit = ~test_bit;
         edge_();
         n_cmp++; if (vv0 !== 1'b1 || vec0 !== 8'hB2) begin n_fail++; $display("FAIL hold: got %b %h want 1 b2", vv0, vec0); end
      end
      test_bit = 1'b1;
      edge_();
      edge_();
      req = 1'b1;
      edge_();
      n_cmp++; if (vv0 !== 1'b0) begin n_fail++; $display("FAIL consume_vv: got %b want 0", vv0); end
      n_cmp++; if (vec0 !== 8'hB2) begin n_fail++; $display("FAIL consume_keep: got %h want b2", vec0); end
      for (int k = 1; k <= 8; k++) begin
         req = (k == 1);
         edge_();
         if (k == 7) begin
            n_cmp++; if (vv0 !== 1'b0) begin n_fail++; $display("FAIL ones_early: got %b want 0", vv0); end
         end
      end
      req = 1'b0;
      n_cmp++; if (vv0 !== 1'b1 || vec0 !== 8'hFF) begin n_fail++; $display("FAIL ones_vec: got %b %h want 1 ff", vv0, vec0); end
   endtask

   task automatic test_async_reset();
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++; if (vec0 !== 8'h00 || vv0 !== 1'b0 || bv0 !== 1'b0) begin n_fail++; $display("FAIL async_rst: got %h %b %b want 00 0 0", vec0, vv0, bv0); end
      edge_();
      n_cmp++; if (vec0 !== 8'h00 || bv0 !== 1'b0) begin n_fail++; $display("FAIL rst_held: got %h %b want 00 0", vec0, bv0); end
      rst_n = 1'b1;
   endtask

   task automatic test_debias();
      logic [19:0] stream;
      stream = 20'h63A59;
      reset_dut();
      en = 1'b1; test_mode = 1'b1; req = 1'b0;
      for (int i = 0; i < 22; i++) begin
         if (i < 20) test_bit = stream[19-i];
         else        test_bit = 1'b0;
         edge_();
         if (i == 20) begin
            n_cmp++; if (vv1 !== 1'b0) begin n_fail++; $display("FAIL vn_early: got %b want 0", vv1); end
         end
      end
      n_cmp++; if (vv1 !== 1'b1) begin n_fail++; $display("FAIL vn_vv: got %b want 1", vv1); end
      n_cmp++; if (vec1 !== 8'h72) begin n_fail++; $display("FAIL vn_vec: got %h want 72", vec1); end
   endtask

   task automatic test_en_drop();
      logic [3:0] a;
      logic [3:0] b;
      a = 4'b1001;
      b = 4'b0110;
      reset_dut();
      en = 1'b1; test_mode = 1'b1; req = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (i < 4) test_bit = a[3-i];
         else       test_bit = 1'b0;
         edge_();
      end
      n_cmp++; if (vec0 !== 8'h09) begin n_fail++; $display("FAIL drop_pre: got %h want 09", vec0); end
      en = 1'b0;
      edge_();
      n_cmp++; if (bv0 !== 1'b0) begin n_fail++; $display("FAIL drop_bv: got %b want 0", bv0); end
      edge_();
      edge_();
      n_cmp++; if (vec0 !== 8'h09 || vv0 !== 1'b0) begin n_fail++; $display("FAIL drop_hold: got %h %b want 09 0", vec0, vv0); end
      en = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (i < 4) test_bit = b[3-i];
         else       test_bit = 1'b0;
         edge_();
         if (i == 0) begin
            n_cmp++; if (bv0 !== 1'b0) begin n_fail++; $display("FAIL reen_bv1: got %b want 0", bv0); end
         end
         if (i == 1) begin
            n_cmp++; if (bv0 !== 1'b1) begin n_fail++; $display("FAIL reen_bv2: got %b want 1", bv0); end
         end
         if (i == 4) begin
            n_cmp++; if (vv0 !== 1'b0 || vec0 !== 8'h4B) begin n_fail++; $display("FAIL reen_part: got %b %h want 0 4b", vv0, vec0); end
         end
      end
      n_cmp++; if (vv0 !== 1'b1 || vec0 !== 8'h96) begin n_fail++; $display("FAIL reen_vec: got %b %h want 1 96", vv0, vec0); end
   endtask

   task automatic test_ring_idle();
      reset_dut();
      en = 1'b0; test_mode = 1'b0; req = 1'b0;
      for (int i = 0; i < 3; i++) begin
         edge_();
         n_cmp++; if (bv0 !== 1'b0) begin n_fail++; $display("FAIL ring_bv: got %b want 0", bv0); end
         n_cmp++; if (u_dut0.ring_s[6] !== 1'b1) begin n_fail++; $display("FAIL ring_static: got %b want 1", u_dut0.ring_s[6]); end
      end
      test_mode = 1'b1;
   endtask

   initial begin
      n_cmp = 0;
      n_fail = 0;
      rst_n = 1'b0; en = 1'b0; req = 1'b0; test_mode = 1'b1; test_bit = 1'b0;
      test_reset();
      test_straight();
      test_hold_consume();
      test_async_reset();
      test_debias();
      test_en_drop();
      test_ring_idle();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
